// File: rtl/fmadd_lzd_normalizer.sv
// Normalises the raw FMADD mantissa sum using the LZD count and produces a bfloat16
// 1.7 mantissa with guard/round/sticky bits. The coarse shift is in S1 and the fine shift in S2.
module fmadd_lzd_normalizer #(
    parameter int MANT_W  = 32,
    parameter int LZ_W    = 5,
    parameter int EXP_W   = 10,
    parameter int OUT_M   = 8,
    parameter int EXP_ADJ = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MANT_W-1:0]    in_mant,
    input  logic [LZ_W-1:0]      in_lz,
    input  logic [EXP_W-1:0]     in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_M-1:0]     out_mant,
    output logic [2:0]           out_grs,
    output logic [EXP_W-1:0]     out_exp,
    output logic                 out_zero,
    output logic                 out_uflow,
    output logic                 out_oflow
);

    localparam int G_BIT = MANT_W - OUT_M - 1;
    localparam int R_BIT = MANT_W - OUT_M - 2;
    localparam logic signed [EXP_W:0] ADJ_C   = (EXP_W+1)'(EXP_ADJ);
    localparam logic signed [EXP_W:0] OFLOW_C = (EXP_W+1)'(255);
    localparam logic signed [EXP_W:0] ZERO_C  = {(EXP_W+1){1'b0}};

    logic                     s2_load_s;
    logic                     s1_load_s;
    logic [MANT_W-1:0]        m1_s;
    logic signed [EXP_W:0]    e1_s;
    logic signed [EXP_W:0]    lz_ext_s;
    logic [MANT_W-1:0]        m2_s;

    logic                     s1_valid_r;
    logic [MANT_W-1:0]        s1_mant_r;
    logic [2:0]               s1_fine_r;
    logic signed [EXP_W:0]    s1_exp_r;
    logic                     s1_zero_r;

    logic [OUT_M-1:0]         nx_mant_s;
    logic [2:0]               nx_grs_s;
    logic [EXP_W-1:0]         nx_exp_s;
    logic                     nx_zero_s;
    logic                     nx_uflow_s;
    logic                     nx_oflow_s;

    // Pipeline advance control: S2 frees when empty or accepted, S1 follows S2.
    always_comb begin
        s2_load_s = !out_valid || out_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        in_ready  = !rst && s1_load_s;
    end

    // Stage 1 datapath: byte-granular coarse shift and widened exponent adjust.
    always_comb begin
        m1_s     = in_mant << {in_lz[LZ_W-1:3], 3'b000};
        lz_ext_s = {{(EXP_W+1-LZ_W){1'b0}}, in_lz};
        e1_s     = $signed({in_exp[EXP_W-1], in_exp}) + ADJ_C - lz_ext_s;
    end

    // Stage 1 register; zero detect comes from the mantissa since in_lz=0 is ambiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= {MANT_W{1'b0}};
            s1_fine_r  <= 3'b000;
            s1_exp_r   <= {(EXP_W+1){1'b0}};
            s1_zero_r  <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mant_r <= m1_s;
                s1_fine_r <= in_lz[2:0];
                s1_exp_r  <= e1_s;
                s1_zero_r <= (in_mant == {MANT_W{1'b0}});
            end
        end
    end

    // Stage 2 datapath: fine shift, GRS extraction and exponent classification by priority.
    always_comb begin
        m2_s       = s1_mant_r << s1_fine_r;
        nx_mant_s  = m2_s[MANT_W-1 -: OUT_M];
        nx_grs_s   = {m2_s[G_BIT], m2_s[R_BIT], |m2_s[R_BIT-1:0]};
        nx_exp_s   = s1_exp_r[EXP_W-1:0];
        nx_zero_s  = 1'b0;
        nx_uflow_s = 1'b0;
        nx_oflow_s = 1'b0;
        if (s1_zero_r) begin
            nx_zero_s = 1'b1;
            nx_mant_s = {OUT_M{1'b0}};
            nx_grs_s  = 3'b000;
            nx_exp_s  = {EXP_W{1'b0}};
        end else if (s1_exp_r <= ZERO_C) begin
            nx_uflow_s = 1'b1;
            nx_mant_s  = {OUT_M{1'b0}};
            nx_grs_s   = 3'b000;
            nx_exp_s   = {EXP_W{1'b0}};
        end else if (s1_exp_r >= OFLOW_C) begin
            nx_oflow_s = 1'b1;
        end else begin
            nx_oflow_s = 1'b0;
        end
    end

    // Stage 2 output register; data holds while out_valid waits for out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mant  <= {OUT_M{1'b0}};
            out_grs   <= 3'b000;
            out_exp   <= {EXP_W{1'b0}};
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            out_oflow <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_mant  <= nx_mant_s;
                out_grs   <= nx_grs_s;
                out_exp   <= nx_exp_s;
                out_zero  <= nx_zero_s;
                out_uflow <= nx_uflow_s;
                out_oflow <= nx_oflow_s;
            end
        end
    end

endmodule

// File: tb/tb_fmadd_lzd_normalizer.sv
// Bench for fmadd_lzd_normalizer: directed corner vectors plus randomized streams
// checked against an arithmetic model through a scoreboard queue.
module tb_fmadd_lzd_normalizer;

    typedef struct packed {
        logic [7:0] mant;
        logic [2:0] grs;
        logic [9:0] exp;
        logic       zero;
        logic       uflow;
        logic       oflow;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mant;
    logic [4:0]  in_lz;
    logic [9:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_mant;
    logic [2:0]  out_grs;
    logic [9:0]  out_exp;
    logic        out_zero;
    logic        out_uflow;
    logic        out_oflow;
    exp_t        got;

    int checks = 0;
    int failures = 0;

    assign got = {out_mant, out_grs, out_exp, out_zero, out_uflow, out_oflow};

    always #5 clk = ~clk;

    fmadd_lzd_normalizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_lz(in_lz), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_grs(out_grs), .out_exp(out_exp),
        .out_zero(out_zero), .out_uflow(out_uflow), .out_oflow(out_oflow)
    );

    // Reference: full shift by lz, exponent = exp + 1 - lz as a plain integer.
    function automatic exp_t model(input logic [31:0] m, input logic [4:0] lz, input logic [9:0] e);
        exp_t r;
        int ea;
        logic [31:0] sh;
        r  = '{8'd0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0};
        ea = int'($signed(e)) + 1 - int'(lz);
        sh = m << lz;
        if (m == 32'd0) begin
            r.zero = 1'b1;
        end else if (ea <= 0) begin
            r.uflow = 1'b1;
        end else begin
            r.mant  = sh[31:24];
            r.grs   = {sh[23], sh[22], |sh[21:0]};
            r.exp   = ea[9:0];
            r.oflow = (ea >= 255);
        end
        return r;
    endfunction

    function automatic logic [4:0] true_lz(input logic [31:0] m);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) return n;
            n = n + 5'd1;
        end
        return 5'd0;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_mant  = 32'd0;
        in_lz    = 5'd0;
        in_exp   = 10'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || got !== exp_t'(24'd0)) begin
            failures++;
            $display("FAIL reset: out_valid=%b in_ready=%b data=%h, want 0 0 000000", out_valid, in_ready, got);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] dm [11] = '{32'h8000_0000, 32'h0000_0001, 32'hC000_0001, 32'h0000_0000,
                                 32'h0020_0000, 32'h8000_0000, 32'h4000_0000, 32'h4000_0000,
                                 32'h0001_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [4:0]  dl [11] = '{5'd0, 5'd31, 5'd0, 5'd0, 5'd10, 5'd0, 5'd1, 5'd1, 5'd15, 5'd0, 5'd0};
        logic [9:0]  de [11] = '{10'd127, 10'd127, 10'd10, 10'd50, 10'd5, 10'd254, 10'd0, 10'd1,
                                 10'd20, 10'd511, 10'h200};
        exp_t        dx [11] = '{'{8'h80, 3'b000, 10'd128, 1'b0, 1'b0, 1'b0},
                                 '{8'h80, 3'b000, 10'd97,  1'b0, 1'b0, 1'b0},
                                 '{8'hC0, 3'b001, 10'd11,  1'b0, 1'b0, 1'b0},
                                 '{8'h00, 3'b000, 10'd0,   1'b1, 1'b0, 1'b0},
                                 '{8'h00, 3'b000, 10'd0,   1'b0, 1'b1, 1'b0},
                                 '{8'h80, 3'b000, 10'd255, 1'b0, 1'b0, 1'b1},
                                 '{8'h00, 3'b000, 10'd0,   1'b0, 1'b1, 1'b0},
                                 '{8'h80, 3'b000, 10'd1,   1'b0, 1'b0, 1'b0},
                                 '{8'hFF, 3'b111, 10'd6,   1'b0, 1'b0, 1'b0},
                                 '{8'h80, 3'b000, 10'h200, 1'b0, 1'b0, 1'b1},
                                 '{8'h00, 3'b000, 10'd0,   1'b0, 1'b1, 1'b0}};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_mant   = dm[i];
            in_lz     = dl[i];
            in_exp    = de[i];
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_early[%0d]: out_valid=%b want 0", i, out_valid);
            end
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || got !== dx[i]) begin
                failures++;
                $display("FAIL directed[%0d]: valid=%b data=%h want 1 %h", i, out_valid, got, dx[i]);
            end
        end
    endtask

    // Streams n random beats; mode 0 full rate, 1 three-cycle stall after first output, 2 random.
    task automatic run_stream(input int n, input int mode, output int iters, output int stalls_seen);
        logic [31:0] sm [$];
        logic [4:0]  sl [$];
        logic [9:0]  se [$];
        exp_t        sb [$];
        exp_t        prev_data;
        logic        prev_hold;
        int          occ;
        int          stall_start;
        logic [31:0] m;
        logic [4:0]  lz;
        for (int i = 0; i < n; i++) begin
            m  = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            lz = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : true_lz(m);
            sm.push_back(m);
            sl.push_back(lz);
            se.push_back(10'($urandom_range(0, 340) - 40));
        end
        iters = 0;
        occ = 0;
        stall_start = -1;
        stalls_seen = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        while ((sm.size() != 0 || sb.size() != 0) && iters < 2000) begin
            @(negedge clk);
            if (mode == 1 && stall_start < 0 && out_valid) stall_start = iters;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = !(stall_start >= 0 && iters < stall_start + 3);
                default: out_ready = ($urandom_range(0, 9) < 6);
            endcase
            if (sm.size() != 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_mant  = sm[0];
                in_lz    = sl[0];
                in_exp   = se[0];
            end else begin
                idle_inputs();
            end
            #1;
            checks++;
            if (in_ready !== ((occ < 2) || out_ready)) begin
                failures++;
                $display("FAIL in_ready[m%0d c%0d]: got %b want %b (occ=%0d)", mode, iters, in_ready, (occ < 2) || out_ready, occ);
            end
            if (in_valid && !in_ready) stalls_seen++;
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || got !== prev_data) begin
                    failures++;
                    $display("FAIL hold_stable[m%0d c%0d]: valid=%b data=%h want 1 %h", mode, iters, out_valid, got, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat[m%0d]: data=%h with empty scoreboard", mode, got);
                end else if (got !== sb[0]) begin
                    failures++;
                    $display("FAIL stream_data[m%0d c%0d]: got %h want %h", mode, iters, got, sb[0]);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                occ--;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(sm[0], sl[0], se[0]));
                void'(sm.pop_front());
                void'(sl.pop_front());
                void'(se.pop_front());
                occ++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = got;
            iters++;
        end
        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        checks++;
        if (sm.size() != 0 || sb.size() != 0) begin
            failures++;
            $display("FAIL stream_timeout[m%0d]: pending_in=%0d pending_out=%0d want 0 0", mode, sm.size(), sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int it;
        int st;
        run_stream(20, 0, it, st);
        checks++;
        if (it != 22) begin
            failures++;
            $display("FAIL throughput: cycles=%0d want 22", it);
        end
    endtask

    task automatic test_backpressure();
        int it;
        int st;
        run_stream(4, 1, it, st);
        checks++;
        if (st == 0) begin
            failures++;
            $display("FAIL backpressure_ready: stalled cycles=%0d want >0", st);
        end
    endtask

    task automatic test_random();
        int it;
        int st;
        run_stream(300, 2, it, st);
    endtask

    task automatic test_reset_flush();
        exp_t xc;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_mant = 32'h0F00_0000; in_lz = 5'd4; in_exp = 10'd60;
        @(posedge clk);
        @(negedge clk);
        in_mant = 32'h0000_3000; in_lz = 5'd18; in_exp = 10'd70;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_mant = 32'h1234_5678; in_lz = 5'd3; in_exp = 10'd80;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready: in_ready=%b want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_mant = 32'h00A0_0000; in_lz = 5'd8; in_exp = 10'd100;
        xc = model(32'h00A0_0000, 5'd8, 10'd100);
        #1;
        checks++;
        if (out_valid !== 1'b0 || got !== exp_t'(24'd0)) begin
            failures++;
            $display("FAIL rst_flush: valid=%b data=%h want 0 000000", out_valid, got);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_stale: out_valid=%b want 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || got !== xc) begin
            failures++;
            $display("FAIL rst_fresh: valid=%b data=%h want 1 %h", out_valid, got, xc);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
